fcs_bit_ser: RTL and testbench

Byte-to-bit serializer that feeds the bit-serial FCS32 stage. Accepts frame bytes on a valid/ready handshake, shifts each byte out LSB-first at one bit per clock, and marks byte, frame-start and frame-end boundaries for the downstream CRC pipeline. It also reports frame length at the final bit and flags framing errors. It enforces a programmable idle gap between frames, so the downstream stage sees a clean frame boundary.

---
 rtl/fcs_bit_ser.sv | 173 +++++++++++++++++
 tb/tb_fcs_bit_ser.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcs_bit_ser.sv
// Byte-to-bit serializer in front of the bit-serial FCS32 stage: holding register plus
// shift register, LSB-first output with byte/frame markers, frame length and framing errors.
module fcs_bit_ser #(
   parameter int GAP_BITS = 8,
   parameter int LEN_W    = 16
) (
   input  logic             bclk_i,
   input  logic             brst_i,
   input  logic [7:0]       byte_i,
   input  logic             sof_i,
   input  logic             eof_i,
   input  logic             vld_i,
   output logic             rdy_o,
   output logic             bit_o,
   output logic             bval_o,
   output logic             bstb_o,
   output logic             bsof_o,
   output logic             beof_o,
   output logic [LEN_W-1:0] len_o,
   output logic             len_val_o,
   output logic             err_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] GAP_LAST = (GAP_BITS > 0) ? 8'(GAP_BITS - 1) : 8'd0;

   state_t           state_q, state_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             hold_full_q, hold_full_d;
   logic [7:0]       hold_byte_q, hold_byte_d;
   logic             hold_sof_q, hold_sof_d;
   logic             hold_eof_q, hold_eof_d;
   logic             sh_full_q, sh_full_d;
   logic [7:0]       sh_byte_q, sh_byte_d;
   logic [2:0]       sh_idx_q, sh_idx_d;
   logic             sh_sof_q, sh_sof_d;
   logic             sh_eof_q, sh_eof_d;
   logic             in_open_q, in_open_d;
   logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             err_q, err_d;

   logic sh_last, enter_gap, gap_done, load, accept, hold_we;

   // Frame-open tracking is done on the input side, so framing errors are judged at acceptance.
   assign sh_last   = sh_full_q & (sh_idx_q == 3'd7);
   assign enter_gap = sh_last & sh_eof_q & (GAP_BITS != 0);
   assign gap_done  = (state_q == ST_GAP) & (gap_cnt_q == GAP_LAST);
   assign load      = hold_full_q & ((state_q == ST_GAP) ? gap_done
                                                         : (!sh_full_q | (sh_last & !enter_gap)));
   assign rdy_o     = !brst_i & (!hold_full_q | load);
   assign accept    = vld_i & rdy_o;
   assign hold_we   = accept & (sof_i | in_open_q);

   assign bval_o      = sh_full_q;
   assign bit_o       = sh_full_q & sh_byte_q[sh_idx_q];
   assign bstb_o      = sh_full_q & (sh_idx_q == 3'd0);
   assign bsof_o      = bstb_o & sh_sof_q;
   assign beof_o      = sh_last & sh_eof_q;
   assign len_val_o   = beof_o;
   assign len_o       = len_val_o ? len_cnt_q : len_q;
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      hold_full_d = hold_full_q;
      hold_byte_d = hold_byte_q;
      hold_sof_d  = hold_sof_q;
      hold_eof_d  = hold_eof_q;
      sh_full_d   = sh_full_q;
      sh_byte_d   = sh_byte_q;
      sh_idx_d    = sh_idx_q;
      sh_sof_d    = sh_sof_q;
      sh_eof_d    = sh_eof_q;
      in_open_d   = in_open_q;
      len_cnt_d   = len_cnt_q;
      len_d       = len_q;
      err_d       = accept & (sof_i == in_open_q);

      if (hold_we) begin
         hold_full_d = 1'b1;
         hold_byte_d = byte_i;
         hold_sof_d  = sof_i;
         hold_eof_d  = eof_i;
         in_open_d   = !eof_i;
      end else if (load) begin
         hold_full_d = 1'b0;
      end

      if (load) begin
         sh_full_d = 1'b1;
         sh_byte_d = hold_byte_q;
         sh_idx_d  = 3'd0;
         sh_sof_d  = hold_sof_q;
         sh_eof_d  = hold_eof_q;
         if (hold_sof_q)
            len_cnt_d = LEN_W'(1);
         else if (len_cnt_q != {LEN_W{1'b1}})
            len_cnt_d = len_cnt_q + LEN_W'(1);
      end else if (sh_last) begin
         sh_full_d = 1'b0;
      end else if (sh_full_q) begin
         sh_idx_d = sh_idx_q + 3'd1;
      end

      if (len_val_o)
         len_d = len_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (load)
               state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (!load && sh_last && sh_eof_q) begin
               state_d   = enter_gap ? ST_GAP : ST_IDLE;
               gap_cnt_d = 8'd0;
            end
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q + 8'd1;
            if (gap_done)
               state_d = load ? ST_SHIFT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge bclk_i) begin
      if (brst_i) begin
         state_q     <= ST_IDLE;
         gap_cnt_q   <= 8'd0;
         hold_full_q <= 1'b0;
         hold_byte_q <= 8'd0;
         hold_sof_q  <= 1'b0;
         hold_eof_q  <= 1'b0;
         sh_full_q   <= 1'b0;
         sh_byte_q   <= 8'd0;
         sh_idx_q    <= 3'd0;
         sh_sof_q    <= 1'b0;
         sh_eof_q    <= 1'b0;
         in_open_q   <= 1'b0;
         len_cnt_q   <= '0;
         len_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         hold_full_q <= hold_full_d;
         hold_byte_q <= hold_byte_d;
         hold_sof_q  <= hold_sof_d;
         hold_eof_q  <= hold_eof_d;
         sh_full_q   <= sh_full_d;
         sh_byte_q   <= sh_byte_d;
         sh_idx_q    <= sh_idx_d;
         sh_sof_q    <= sh_sof_d;
         sh_eof_q    <= sh_eof_d;
         in_open_q   <= in_open_d;
         len_cnt_q   <= len_cnt_d;
         len_q       <= len_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_fcs_bit_ser.sv
// Directed bench for fcs_bit_ser: two instances (GAP_BITS 8 and 12) share the stimulus;
// per-edge output logs are inspected by one task per scenario.
module tb_fcs_bit_ser;

   logic        clk = 1'b0;
   logic        brst_i = 1'b1;
   logic [7:0]  byte_i = 8'd0;
   logic        sof_i = 1'b0, eof_i = 1'b0, vld_i = 1'b0;

   logic        rdy8, bit8, bval8, bstb8, bsof8, beof8, lv8, err8;
   logic [15:0] len8;
   logic [1:0]  st8;
   logic        rdy12, bit12, bval12, bstb12, bsof12, beof12, lv12, err12;
   logic [15:0] len12;
   logic [1:0]  st12;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   localparam int LOGN = 4096;
   logic        bval_l [LOGN], bit_l [LOGN], bstb_l [LOGN], bsof_l [LOGN];
   logic        beof_l [LOGN], lv_l [LOGN], err_l [LOGN], rdy_l [LOGN];
   logic [15:0] len_l [LOGN];
   logic        bval12_l [LOGN], bit12_l [LOGN], bsof12_l [LOGN], beof12_l [LOGN];
   logic [15:0] len12_l [LOGN];

   fcs_bit_ser #(.GAP_BITS(8), .LEN_W(16)) dut (
      .bclk_i(clk), .brst_i(brst_i), .byte_i(byte_i), .sof_i(sof_i), .eof_i(eof_i),
      .vld_i(vld_i), .rdy_o(rdy8), .bit_o(bit8), .bval_o(bval8), .bstb_o(bstb8),
      .bsof_o(bsof8), .beof_o(beof8), .len_o(len8), .len_val_o(lv8), .err_o(err8),
      .dbg_state_o(st8)
   );

   fcs_bit_ser #(.GAP_BITS(12), .LEN_W(16)) dut12 (
      .bclk_i(clk), .brst_i(brst_i), .byte_i(byte_i), .sof_i(sof_i), .eof_i(eof_i),
      .vld_i(vld_i), .rdy_o(rdy12), .bit_o(bit12), .bval_o(bval12), .bstb_o(bstb12),
      .bsof_o(bsof12), .beof_o(beof12), .len_o(len12), .len_val_o(lv12), .err_o(err12),
      .dbg_state_o(st12)
   );

   // clock / edge counter / per-edge log (log[k] = outputs after edge k)
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LOGN) begin
         bval_l[cyc] = bval8;  bit_l[cyc] = bit8;   bstb_l[cyc] = bstb8;
         bsof_l[cyc] = bsof8;  beof_l[cyc] = beof8; lv_l[cyc] = lv8;
         err_l[cyc] = err8;    rdy_l[cyc] = rdy8;   len_l[cyc] = len8;
         bval12_l[cyc] = bval12; bit12_l[cyc] = bit12; bsof12_l[cyc] = bsof12;
         beof12_l[cyc] = beof12; len12_l[cyc] = len12;
      end
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      brst_i = 1'b1;
      vld_i = 1'b0;
      repeat (2) @(negedge clk);
      brst_i = 1'b0;
   endtask

   task automatic wait_until(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic s, input logic e, input bit use12,
                       output int edge_n);
      int t;
      t = 0;
      @(negedge clk);
      byte_i = b; sof_i = s; eof_i = e; vld_i = 1'b1;
      while (((use12 ? rdy12 : rdy8) !== 1'b1) && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL send_timeout: byte %h rdy_o stayed %b, required 1", b, use12 ? rdy12 : rdy8);
      end
      edge_n = cyc + 1;
      @(posedge clk);
      #1;
      vld_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      brst_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rdy8, rdy12} !== 2'b00) begin
         errors++; $display("FAIL reset_rdy: got %b%b, required 00", rdy8, rdy12);
      end
      checks++;
      if ({bit8, bval8, bstb8, bsof8, beof8, lv8, err8} !== 7'd0 || len8 !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b len %0d, required 0000000 len 0",
                  {bit8, bval8, bstb8, bsof8, beof8, lv8, err8}, len8);
      end
      brst_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({rdy8, rdy12} !== 2'b11) begin
         errors++; $display("FAIL reset_rdy_after: got %b%b, required 11", rdy8, rdy12);
      end
   endtask

   task automatic test_single();
      int n, zeros;
      logic [7:0] e;
      e = 8'hA5;
      do_reset();
      send(8'hA5, 1'b1, 1'b1, 1'b0, n);
      wait_until(n + 20);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bval_l[n+1+k] !== 1'b1 || bit_l[n+1+k] !== e[k]) begin
            errors++;
            $display("FAIL single_bit%0d: got bval %b bit %b, required 1 %b",
                     k, bval_l[n+1+k], bit_l[n+1+k], e[k]);
         end
      end
      checks++;
      if ({bsof_l[n+1], bstb_l[n+1], bsof_l[n+2], bstb_l[n+2]} !== 4'b1100) begin
         errors++;
         $display("FAIL single_sof: got %b, required 1100",
                  {bsof_l[n+1], bstb_l[n+1], bsof_l[n+2], bstb_l[n+2]});
      end
      checks++;
      if ({beof_l[n+8], lv_l[n+8], beof_l[n+7], lv_l[n+7]} !== 4'b1100 || len_l[n+8] !== 16'd1) begin
         errors++;
         $display("FAIL single_eof: got %b len %0d, required 1100 len 1",
                  {beof_l[n+8], lv_l[n+8], beof_l[n+7], lv_l[n+7]}, len_l[n+8]);
      end
      zeros = 0;
      for (int k = 9; k <= 16; k++) if (bval_l[n+k] === 1'b0) zeros++;
      checks++;
      if (zeros != 8 || len_l[n+12] !== 16'd1) begin
         errors++;
         $display("FAIL single_gap: got %0d idle cycles len %0d, required 8 len 1", zeros, len_l[n+12]);
      end
   endtask

   task automatic test_back_to_back();
      int n, m, nval, nstb;
      logic [7:0] msg [9];
      logic [7:0] got;
      logic [31:0] crc;
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      do_reset();
      send(msg[0], 1'b1, 1'b0, 1'b0, n);
      for (int i = 1; i < 9; i++) send(msg[i], 1'b0, (i == 8), 1'b0, m);
      wait_until(n + 80);
      nval = 0; nstb = 0; crc = 32'hFFFF_FFFF;
      for (int k = 1; k <= 72; k++) begin
         if (bval_l[n+k] === 1'b1) nval++;
         if (bstb_l[n+k] === 1'b1) nstb++;
         crc = (crc[0] ^ bit_l[n+k]) ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
      end
      checks++;
      if (nval != 72 || nstb != 9 || bval_l[n+73] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_counts: got bval %0d stb %0d tail %b, required 72 9 0",
                  nval, nstb, bval_l[n+73]);
      end
      for (int i = 0; i < 9; i++) begin
         for (int j = 0; j < 8; j++) got[j] = bit_l[n+1+8*i+j];
         checks++;
         if (got !== msg[i]) begin
            errors++; $display("FAIL b2b_byte%0d: got %h, required %h", i, got, msg[i]);
         end
      end
      checks++;
      if (beof_l[n+72] !== 1'b1 || lv_l[n+72] !== 1'b1 || len_l[n+72] !== 16'd9) begin
         errors++;
         $display("FAIL b2b_len: got beof %b lv %b len %0d, required 1 1 9",
                  beof_l[n+72], lv_l[n+72], len_l[n+72]);
      end
      checks++;
      if (~crc !== 32'hCBF4_3926) begin
         errors++; $display("FAIL b2b_crc: got %h, required cbf43926", ~crc);
      end
   endtask

   task automatic test_gap12();
      int n, m, zeros;
      logic [7:0] got;
      logic [7:0] fb [2];
      fb = '{8'h33, 8'h44};
      do_reset();
      send(8'h11, 1'b1, 1'b0, 1'b1, n);
      send(8'h22, 1'b0, 1'b1, 1'b1, m);
      send(8'h33, 1'b1, 1'b0, 1'b1, m);
      send(8'h44, 1'b0, 1'b1, 1'b1, m);
      wait_until(n + 50);
      zeros = 0;
      for (int k = 17; k <= 28; k++) if (bval12_l[n+k] === 1'b0) zeros++;
      checks++;
      if (beof12_l[n+16] !== 1'b1 || zeros != 12 || bsof12_l[n+29] !== 1'b1) begin
         errors++;
         $display("FAIL gap12_spacing: got beof %b idle %0d bsof %b, required 1 12 1",
                  beof12_l[n+16], zeros, bsof12_l[n+29]);
      end
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 8; j++) got[j] = bit12_l[n+29+8*i+j];
         checks++;
         if (got !== fb[i]) begin
            errors++; $display("FAIL gap12_byte%0d: got %h, required %h", i, got, fb[i]);
         end
      end
      checks++;
      if (beof12_l[n+44] !== 1'b1 || len12_l[n+44] !== 16'd2) begin
         errors++;
         $display("FAIL gap12_len: got beof %b len %0d, required 1 2", beof12_l[n+44], len12_l[n+44]);
      end
   endtask

   task automatic test_no_sof();
      int n, p, nval, nerr;
      logic [7:0] got;
      do_reset();
      send(8'h3C, 1'b0, 1'b0, 1'b0, n);
      wait_until(n + 12);
      nval = 0;
      for (int k = 0; k < 12; k++) if (bval_l[n+k] === 1'b1) nval++;
      checks++;
      if (err_l[n] !== 1'b1 || err_l[n+1] !== 1'b0 || nval != 0 || rdy_l[n] !== 1'b1) begin
         errors++;
         $display("FAIL nosof_err: got err %b%b bval %0d rdy %b, required 10 0 1",
                  err_l[n], err_l[n+1], nval, rdy_l[n]);
      end
      send(8'h5A, 1'b1, 1'b1, 1'b0, p);
      wait_until(p + 12);
      for (int j = 0; j < 8; j++) got[j] = bit_l[p+1+j];
      nerr = 0;
      for (int k = p; k <= p + 10; k++) if (err_l[k] === 1'b1) nerr++;
      checks++;
      if (got !== 8'h5A || bsof_l[p+1] !== 1'b1 || beof_l[p+8] !== 1'b1 || nerr != 0) begin
         errors++;
         $display("FAIL nosof_next: got %h sof %b eof %b errs %0d, required 5a 1 1 0",
                  got, bsof_l[p+1], beof_l[p+8], nerr);
      end
   endtask

   task automatic test_abort();
      int n, m, neof;
      logic [7:0] got;
      do_reset();
      send(8'h01, 1'b1, 1'b0, 1'b0, n);
      send(8'h02, 1'b0, 1'b0, 1'b0, m);
      send(8'h03, 1'b0, 1'b0, 1'b0, m);
      send(8'h0A, 1'b1, 1'b0, 1'b0, m);
      send(8'h0B, 1'b0, 1'b1, 1'b0, m);
      wait_until(n + 45);
      checks++;
      if (err_l[n+17] !== 1'b1 || err_l[n+18] !== 1'b0 || err_l[n+16] !== 1'b0) begin
         errors++;
         $display("FAIL abort_err: got %b%b%b, required 010", err_l[n+16], err_l[n+17], err_l[n+18]);
      end
      neof = 0;
      for (int k = 1; k <= 24; k++) if (beof_l[n+k] === 1'b1 || lv_l[n+k] === 1'b1) neof++;
      checks++;
      if (neof != 0 || bsof_l[n+25] !== 1'b1) begin
         errors++;
         $display("FAIL abort_old: got eof pulses %0d new bsof %b, required 0 1", neof, bsof_l[n+25]);
      end
      for (int j = 0; j < 8; j++) got[j] = bit_l[n+25+j];
      checks++;
      if (got !== 8'h0A || beof_l[n+40] !== 1'b1 || len_l[n+40] !== 16'd2) begin
         errors++;
         $display("FAIL abort_new: got %h beof %b len %0d, required 0a 1 2",
                  got, beof_l[n+40], len_l[n+40]);
      end
   endtask

   task automatic test_mid_reset();
      int n, m, bad;
      logic [7:0] got;
      do_reset();
      send(8'h10, 1'b1, 1'b0, 1'b0, n);
      send(8'h20, 1'b0, 1'b0, 1'b0, m);
      send(8'h30, 1'b0, 1'b1, 1'b0, m);
      wait_until(n + 13);
      brst_i = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy8 !== 1'b0 || {bit8, bval8, bstb8, beof8, lv8, err8} !== 6'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got rdy %b outs %b, required 0 000000",
                  rdy8, {bit8, bval8, bstb8, beof8, lv8, err8});
      end
      @(negedge clk);
      brst_i = 1'b0;
      wait_until(n + 45);
      bad = 0;
      for (int k = n + 14; k <= n + 44; k++) if (bval_l[k] === 1'b1 || beof_l[k] === 1'b1) bad++;
      checks++;
      if (bval_l[n+13] !== 1'b1 || bad != 0 || len_l[n+14] !== 16'd0) begin
         errors++;
         $display("FAIL midrst_silent: got pre %b later %0d len %0d, required 1 0 0",
                  bval_l[n+13], bad, len_l[n+14]);
      end
      send(8'hA5, 1'b1, 1'b1, 1'b0, m);
      wait_until(m + 12);
      for (int j = 0; j < 8; j++) got[j] = bit_l[m+1+j];
      checks++;
      if (got !== 8'hA5 || bsof_l[m+1] !== 1'b1 || beof_l[m+8] !== 1'b1 || len_l[m+8] !== 16'd1) begin
         errors++;
         $display("FAIL midrst_fresh: got %h sof %b eof %b len %0d, required a5 1 1 1",
                  got, bsof_l[m+1], beof_l[m+8], len_l[m+8]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gap12();
      test_no_sof();
      test_abort();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
